// File: rtl/keypad_matrix_model.sv
// Stand-in for the switch side of a 4x4 matrix keypad: replays handshaken key codes
// as timed presses on the active-low row lines, with optional contact bounce.
module keypad_matrix_model #(
    parameter int HOLD_CYCLES    = 64,
    parameter int GAP_CYCLES     = 16,
    parameter int BOUNCE_PERIODS = 0,
    parameter int BOUNCE_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic       cancel,
    output logic       pressed,
    output logic       busy
);

    localparam int BOUNCE_TOTAL = BOUNCE_PERIODS * BOUNCE_LEN;
    localparam int MAX_HG       = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_LEN      = (MAX_HG > BOUNCE_TOTAL) ? MAX_HG : BOUNCE_TOTAL;
    localparam int CW           = $clog2(MAX_LEN) + 1;

    localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD    = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] BOUNCE_LOAD = CW'((BOUNCE_TOTAL > 0) ? BOUNCE_TOTAL - 1 : 0);
    localparam logic LAST_HALF_ODD = (BOUNCE_PERIODS > 0) && (((BOUNCE_PERIODS - 1) % 2) != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAKE,
        S_HOLD,
        S_BREAK,
        S_GAP
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    key_col, key_row;
    logic          handshake;
    logic          half_odd;

    // Returns {column, row} of a key code on the physical matrix.
    function automatic logic [3:0] key_position(input logic [3:0] code);
        key_position = 4'b0000;
        case (code)
            4'd1:  key_position = {2'd0, 2'd0};
            4'd4:  key_position = {2'd0, 2'd1};
            4'd7:  key_position = {2'd0, 2'd2};
            4'd14: key_position = {2'd0, 2'd3};
            4'd2:  key_position = {2'd1, 2'd0};
            4'd5:  key_position = {2'd1, 2'd1};
            4'd8:  key_position = {2'd1, 2'd2};
            4'd0:  key_position = {2'd1, 2'd3};
            4'd3:  key_position = {2'd2, 2'd0};
            4'd6:  key_position = {2'd2, 2'd1};
            4'd9:  key_position = {2'd2, 2'd2};
            4'd15: key_position = {2'd2, 2'd3};
            4'd10: key_position = {2'd3, 2'd0};
            4'd11: key_position = {2'd3, 2'd1};
            4'd12: key_position = {2'd3, 2'd2};
            4'd13: key_position = {2'd3, 2'd3};
        endcase
    endfunction

    assign key_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign handshake = key_valid && key_ready;

    // The counter runs down through a bounce phase, so half-period parity is taken from the
    // end and corrected by the parity of the last half-period index.
    assign half_odd = (((int'(cnt) / BOUNCE_LEN) % 2) != 0) ^ LAST_HALF_ODD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            key_col <= 2'd0;
            key_row <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (handshake) begin
                {key_col, key_row} <= key_position(key_code);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt != '0) ? cnt - 1'b1 : cnt;
        case (state)
            S_IDLE: begin
                if (handshake) begin
                    if (BOUNCE_PERIODS > 0) begin
                        state_nxt = S_MAKE;
                        cnt_nxt   = BOUNCE_LOAD;
                    end else begin
                        state_nxt = S_HOLD;
                        cnt_nxt   = HOLD_LOAD;
                    end
                end
            end
            S_MAKE: begin
                if (cnt == '0) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    if (BOUNCE_PERIODS > 0) begin
                        state_nxt = S_BREAK;
                        cnt_nxt   = BOUNCE_LOAD;
                    end else begin
                        state_nxt = S_GAP;
                        cnt_nxt   = GAP_LOAD;
                    end
                end
            end
            S_BREAK: begin
                if (cnt == '0) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        // An abort always guarantees a full released gap before the next key.
        if (cancel && (state == S_MAKE || state == S_HOLD || state == S_BREAK)) begin
            state_nxt = S_GAP;
            cnt_nxt   = GAP_LOAD;
        end
    end

    always_comb begin
        pressed = 1'b0;
        case (state)
            S_MAKE:  pressed = !half_odd;
            S_HOLD:  pressed = 1'b1;
            S_BREAK: pressed = half_odd;
            default: pressed = 1'b0;
        endcase
    end

    // Combinational path from cols so the scanner sees the switch in the same cycle it strobes.
    always_comb begin
        rows = 4'b1111;
        if (pressed && !cols[key_col]) begin
            rows[key_row] = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_model.sv
// Bench for keypad_matrix_model: three parameterisations share one column bus, and a
// behavioural scanner decodes the rows so injected codes are scoreboarded end to end.
module tb_keypad_matrix_model;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cols;
    logic [3:0] drv_cols  = 4'hF;
    logic [3:0] scan_cols = 4'hF;
    logic       scan_en   = 1'b0;

    logic [3:0] rows_a, rows_b, rows_c;
    logic [3:0] key_code_a = 4'd0, key_code_b = 4'd0, key_code_c = 4'd0;
    logic       key_valid_a = 1'b0, key_valid_b = 1'b0, key_valid_c = 1'b0;
    logic       cancel_a = 1'b0, cancel_b = 1'b0, cancel_c = 1'b0;
    logic       ready_a, ready_b, ready_c;
    logic       pressed_a, pressed_b, pressed_c;
    logic       busy_a, busy_b, busy_c;

    int checks   = 0;
    int failures = 0;

    // Physical key layout, indexed by column*4 + row.
    int code_at [16] = '{1, 4, 7, 14, 2, 5, 8, 0, 3, 6, 9, 15, 10, 11, 12, 13};
    int bnc_pat [19] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0};

    int   exp_q [$];
    int   exp_code;
    int   cur_code = 0;
    int   cur_pos  = 0;
    int   scan_col = 0;
    int   row_idx  = 0;
    int   seen_code = 0;
    logic seen = 1'b0, prev_seen = 1'b0;
    int   sweep_bad  = 0;
    int   code0_hits = 0;

    always #5 clk = ~clk;

    assign cols = scan_en ? scan_cols : drv_cols;

    keypad_matrix_model dut_a (
        .clk(clk), .rst_n(rst_n), .cols(cols), .rows(rows_a),
        .key_code(key_code_a), .key_valid(key_valid_a), .key_ready(ready_a),
        .cancel(cancel_a), .pressed(pressed_a), .busy(busy_a)
    );

    keypad_matrix_model #(.HOLD_CYCLES(8), .GAP_CYCLES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .cols(cols), .rows(rows_b),
        .key_code(key_code_b), .key_valid(key_valid_b), .key_ready(ready_b),
        .cancel(cancel_b), .pressed(pressed_b), .busy(busy_b)
    );

    keypad_matrix_model #(.HOLD_CYCLES(4), .GAP_CYCLES(3), .BOUNCE_PERIODS(3), .BOUNCE_LEN(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .cols(cols), .rows(rows_c),
        .key_code(key_code_c), .key_valid(key_valid_c), .key_ready(ready_c),
        .cancel(cancel_c), .pressed(pressed_c), .busy(busy_c)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Presents one key for a single cycle; call just after a falling edge with the DUT idle.
    task automatic applyStimulus(input int which, input logic [3:0] code);
        case (which)
            0: begin key_code_a = code; key_valid_a = 1'b1; end
            1: begin key_code_b = code; key_valid_b = 1'b1; end
            default: begin key_code_c = code; key_valid_c = 1'b1; end
        endcase
        @(negedge clk);
        key_valid_a = 1'b0;
        key_valid_b = 1'b0;
        key_valid_c = 1'b0;
    endtask

    task automatic waitReady(input int which, input int budget);
        int   n = 0;
        logic rdy;
        rdy = (which == 0) ? ready_a : (which == 1) ? ready_b : ready_c;
        while (n < budget && !rdy) begin
            @(negedge clk);
            n++;
            rdy = (which == 0) ? ready_a : (which == 1) ? ready_b : ready_c;
        end
        if (!rdy) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_ready dut=%0d actual=0 expected=1 within %0d cycles", which, budget);
        end
    endtask

    function automatic int pos_of(input int code);
        for (int p = 0; p < 16; p++) begin
            if (code_at[p] == code) return p;
        end
        return 0;
    endfunction

    // Behavioural scanner on dut_b: samples rows for the strobed column, then advances.
    // A key reported by a full scan after a key-free scan is one decoded press.
    always @(negedge clk) begin
        if (scan_en) begin
            if (rows_b != 4'hF) begin
                row_idx = 0;
                for (int r = 3; r >= 0; r--) begin
                    if (!rows_b[r]) row_idx = r;
                end
                if (scan_col != cur_pos / 4 || rows_b != ~(4'b0001 << (cur_pos % 4))) sweep_bad++;
                if (cur_code == 0) code0_hits++;
                seen      = 1'b1;
                seen_code = code_at[scan_col * 4 + row_idx];
            end
            if (scan_col == 3) begin
                if (seen && !prev_seen) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL scan_code actual=%0d expected=none", seen_code);
                    end else begin
                        exp_code = exp_q.pop_front();
                        if (seen_code != exp_code) begin
                            failures++;
                            $display("[TB] FAIL scan_code actual=%0d expected=%0d", seen_code, exp_code);
                        end
                    end
                end
                prev_seen = seen;
                seen      = 1'b0;
            end
            scan_col  = (scan_col + 1) % 4;
            scan_cols = ~(4'b0001 << scan_col);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int bad;
        int pcount;
        logic [3:0] exp_rows;

        rst_n    = 1'b0;
        drv_cols = 4'h0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_rows_a", 32'(rows_a), 32'hF);
        checkOutput("reset_rows_b", 32'(rows_b), 32'hF);
        checkOutput("reset_rows_c", 32'(rows_c), 32'hF);
        checkOutput("reset_ready_a", 32'(ready_a), 32'h1);
        checkOutput("reset_busy_a", 32'(busy_a), 32'h0);
        checkOutput("reset_pressed_a", 32'(pressed_a), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] key 5, defaults, cycling columns");
        drv_cols = 4'hF;
        applyStimulus(0, 4'd5);
        bad    = 0;
        pcount = 0;
        for (int k = 1; k <= 84; k++) begin
            if (k > 1) @(negedge clk);
            drv_cols = ~(4'b0001 << (k % 4));
            #1;
            exp_rows = ((k <= 64) && drv_cols == 4'b1101) ? 4'b1101 : 4'b1111;
            if (rows_a != exp_rows) bad++;
            if (busy_a == ready_a) bad++;
            if (pressed_a) pcount++;
            if (k == 80) checkOutput("t1_ready_c80", 32'(ready_a), 32'h0);
            if (k == 81) checkOutput("t1_ready_c81", 32'(ready_a), 32'h1);
        end
        checkOutput("t1_rows_pattern", bad, 0);
        checkOutput("t1_pressed_cycles", pcount, 64);

        $display("[TB] key 10, multi-column strobe, cancel, valid held while busy");
        @(negedge clk);
        key_code_a  = 4'd10;
        key_valid_a = 1'b1;
        @(negedge clk);
        key_code_a = 4'd3;
        drv_cols   = 4'b0110;
        #1;
        checkOutput("t4_multi_col", 32'(rows_a), 32'hE);
        drv_cols = 4'b1111;
        #1;
        checkOutput("t4_cols_idle", 32'(rows_a), 32'hF);
        @(negedge clk);
        drv_cols = 4'b0111;
        #1;
        checkOutput("t5_code_ignored", 32'(rows_a), 32'hE);
        repeat (8) @(negedge clk);
        #1;
        checkOutput("t5_hold_c10", 32'(pressed_a), 32'h1);
        cancel_a = 1'b1;
        @(negedge clk);
        cancel_a = 1'b0;
        #1;
        checkOutput("t5_cancel_pressed", 32'(pressed_a), 32'h0);
        checkOutput("t5_cancel_busy", 32'(busy_a), 32'h1);
        bad = 0;
        for (int k = 12; k <= 26; k++) begin
            @(negedge clk);
            #1;
            if (pressed_a || ready_a) bad++;
        end
        checkOutput("t5_gap_released", bad, 0);
        @(negedge clk);
        #1;
        checkOutput("t5_ready_after_gap", 32'(ready_a), 32'h1);
        @(negedge clk);
        key_valid_a = 1'b0;
        drv_cols    = 4'b1011;
        #1;
        checkOutput("t5_next_key_rows", 32'(rows_a), 32'hE);

        $display("[TB] key 13 with bounce");
        @(negedge clk);
        applyStimulus(2, 4'd13);
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            if (k <= 19) checkOutput($sformatf("t3_pressed_c%0d", k), 32'(pressed_c), 32'(bnc_pat[k-1]));
            if (k == 19) checkOutput("t3_ready_c19", 32'(ready_c), 32'h0);
            if (k == 20) checkOutput("t3_ready_c20", 32'(ready_c), 32'h1);
        end

        $display("[TB] sweep of all codes through the scanner");
        scan_col  = 0;
        scan_cols = 4'b1110;
        seen      = 1'b0;
        prev_seen = 1'b0;
        scan_en   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cur_code = i;
            cur_pos  = pos_of(i);
            exp_q.push_back(i);
            applyStimulus(1, 4'(i));
            waitReady(1, 40);
            repeat (6) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        scan_en = 1'b0;
        checkOutput("t2_queue_drained", exp_q.size(), 0);
        checkOutput("t2_rows_shape", sweep_bad, 0);
        checkOutput("t2_code0_seen", 32'(code0_hits > 0), 32'h1);

        $display("[TB] asynchronous reset mid-hold");
        waitReady(0, 200);
        @(negedge clk);
        applyStimulus(0, 4'd1);
        drv_cols = 4'b1110;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("t6_pre_reset_rows", 32'(rows_a), 32'hE);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_reset_rows", 32'(rows_a), 32'hF);
        checkOutput("t6_reset_busy", 32'(busy_a), 32'h0);
        checkOutput("t6_reset_ready", 32'(ready_a), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(0, 4'd1);
        #1;
        checkOutput("t6_after_reset_pressed", 32'(pressed_a), 32'h1);
        checkOutput("t6_after_reset_rows", 32'(rows_a), 32'hE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
